// File: rtl/text_overlay_ctrl_pkg.sv
// Shared types and constants for the text overlay controller.
package text_overlay_ctrl_pkg;

  // Overlay FSM encoding.
  typedef enum logic [1:0] {
    StOff   = 2'd0,
    StArmed = 2'd1,
    StOn    = 2'd2,
    StDrain = 2'd3
  } state_e;

  // Character cells are CellSize x CellSize pixels.
  localparam int unsigned CellSize = 8;
  localparam int unsigned CellBits = 3;

  // Raster counter widths.
  localparam int unsigned HcntW = 11;
  localparam int unsigned VcntW = 10;

  // Side-band information that travels alongside the memory lookups.
  typedef struct packed {
    logic                win;
    logic                act;
    logic [CellBits-1:0] hsub;
    logic [CellBits-1:0] vsub;
  } side_t;

  // Overlay pixels are produced while the frame is committed to the overlay.
  function automatic logic is_active(state_e s);
    return (s == StOn) || (s == StDrain);
  endfunction

endpackage

// File: rtl/sync_counters.sv
// Sync edge detection and raster position counters.
module sync_counters
  import text_overlay_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync,
  input  logic             vsync,
  output logic             vs_rise,
  output logic [HcntW-1:0] hcnt,
  output logic [VcntW-1:0] vcnt
);

  logic             hsync_q, vsync_q;
  logic             hs_rise;
  logic [HcntW-1:0] hcnt_q;
  logic [VcntW-1:0] vcnt_q;

  assign hs_rise = hsync & ~hsync_q;
  assign vs_rise = vsync & ~vsync_q;
  assign hcnt    = hcnt_q;
  assign vcnt    = vcnt_q;

  // Sync history and saturating pixel/line counters; a frame start beats a line start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
    end else begin
      hsync_q <= hsync;
      vsync_q <= vsync;

      if (hs_rise) begin
        hcnt_q <= '0;
      end else if (hcnt_q != '1) begin
        hcnt_q <= hcnt_q + 1'b1;
      end

      if (vs_rise) begin
        vcnt_q <= '0;
      end else if (hs_rise && (vcnt_q != '1)) begin
        vcnt_q <= vcnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/text_overlay_ctrl.sv
// Character-cell text overlay: frame-aligned enable FSM plus a 5-cycle
// text RAM / font ROM lookup pipeline producing one dot per pixel.
module text_overlay_ctrl
  import text_overlay_ctrl_pkg::*;
#(
  parameter int unsigned COLS = 16,
  parameter int unsigned ROWS = 4,
  parameter int unsigned X0   = 64,
  parameter int unsigned Y0   = 32,
  localparam int unsigned AddrW = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             overlay_en,
  output logic [AddrW-1:0] text_addr,
  input  logic [7:0]       text_data,
  output logic [10:0]      font_addr,
  input  logic [7:0]       font_data,
  output logic             pixel_en,
  output logic             dot,
  output logic             busy
);

  logic             vs_rise;
  logic [HcntW-1:0] hcnt;
  logic [VcntW-1:0] vcnt;

  sync_counters u_sync_counters (
    .clk     (clk),
    .rst     (rst),
    .hsync   (hsync),
    .vsync   (vsync),
    .vs_rise (vs_rise),
    .hcnt    (hcnt),
    .vcnt    (vcnt)
  );

  state_e state_q, state_d;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StOff;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: overlay only switches on or off at a frame start; a request
  // withdrawn before the frame start cancels the pending switch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StOff: begin
        if (overlay_en) state_d = StArmed;
      end
      StArmed: begin
        if (!overlay_en)  state_d = StOff;
        else if (vs_rise) state_d = StOn;
      end
      StOn: begin
        if (!overlay_en) state_d = StDrain;
      end
      StDrain: begin
        if (overlay_en)   state_d = StOn;
        else if (vs_rise) state_d = StOff;
      end
      default: state_d = StOff;
    endcase
  end

  assign busy = (state_q != StOff);

  logic [HcntW-1:0] hrel;
  logic [VcntW-1:0] vrel;
  logic             in_win;
  logic [AddrW-1:0] cell_idx;
  side_t            side0;

  // Window decode and character cell index for the current raster position.
  always_comb begin
    hrel     = hcnt - HcntW'(X0);
    vrel     = vcnt - VcntW'(Y0);
    in_win   = (hcnt >= HcntW'(X0)) && (hcnt < HcntW'(X0 + CellSize * COLS)) &&
               (vcnt >= VcntW'(Y0)) && (vcnt < VcntW'(Y0 + CellSize * ROWS));
    cell_idx = AddrW'(32'(vrel[VcntW-1:CellBits]) * COLS + 32'(hrel[HcntW-1:CellBits]));
    side0.win  = in_win;
    side0.act  = is_active(state_q);
    side0.hsub = hrel[CellBits-1:0];
    side0.vsub = vrel[CellBits-1:0];
  end

  side_t            side_q [4];
  logic [AddrW-1:0] text_addr_q;
  logic [10:0]      font_addr_q;
  logic             pixel_en_q, dot_q;

  // Lookup pipeline: text address, then font address once the character code
  // returns, then the selected glyph bit once the font row returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) side_q[i] <= '0;
      text_addr_q <= '0;
      font_addr_q <= '0;
      pixel_en_q  <= 1'b0;
      dot_q       <= 1'b0;
    end else begin
      side_q[0] <= side0;
      side_q[1] <= side_q[0];
      side_q[2] <= side_q[1];
      side_q[3] <= side_q[2];
      // Hold the last cell address outside the window to avoid needless RAM toggling.
      if (in_win) text_addr_q <= cell_idx;
      font_addr_q <= {text_data, side_q[1].vsub};
      pixel_en_q  <= side_q[3].win & side_q[3].act;
      // MSB is the leftmost pixel of the glyph row.
      dot_q       <= side_q[3].win & side_q[3].act & font_data[~side_q[3].hsub];
    end
  end

  assign text_addr = text_addr_q;
  assign font_addr = font_addr_q;
  assign pixel_en  = pixel_en_q;
  assign dot       = dot_q;

endmodule

// File: tb/tb_text_overlay_ctrl.sv
// Self-checking bench for text_overlay_ctrl with a cycle-level reference model.
module tb_text_overlay_ctrl;

  localparam int COLS = 16;
  localparam int ROWS = 4;
  localparam int X0   = 64;
  localparam int Y0   = 32;
  localparam int AW   = $clog2(COLS * ROWS);

  logic          clk = 1'b0;
  logic          rst;
  logic          hsync, vsync, overlay_en;
  logic [AW-1:0] text_addr;
  logic [7:0]    text_data;
  logic [10:0]   font_addr;
  logic [7:0]    font_data;
  logic          pixel_en, dot, busy;

  always #5 clk = ~clk;

  text_overlay_ctrl #(
    .COLS (COLS),
    .ROWS (ROWS),
    .X0   (X0),
    .Y0   (Y0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hsync      (hsync),
    .vsync      (vsync),
    .overlay_en (overlay_en),
    .text_addr  (text_addr),
    .text_data  (text_data),
    .font_addr  (font_addr),
    .font_data  (font_data),
    .pixel_en   (pixel_en),
    .dot        (dot),
    .busy       (busy)
  );

  // Memories with registered reads.
  logic [7:0] text_ram [COLS*ROWS];
  logic [7:0] font_rom [2048];

  always @(posedge clk) begin
    text_data <= text_ram[text_addr];
    font_data <= font_rom[font_addr];
  end

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state for the current cycle.
  int          m_h, m_v, m_st, m_ta;   // m_st: 0 off, 1 armed, 2 on, 3 drain
  bit          m_hs, m_vs;
  bit          pe_p [5];
  bit          dt_p [5];
  logic [10:0] fa_p [3];
  bit          fv_p [3];

  int       pe_cnt;
  bit       cap_on;
  int       cap_n, first_h, first_v;
  bit [7:0] cap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_v = 0; m_st = 0; m_ta = 0; m_hs = 0; m_vs = 0;
    for (int i = 0; i < 5; i++) begin pe_p[i] = 0; dt_p[i] = 0; end
    for (int i = 0; i < 3; i++) begin fa_p[i] = '0; fv_p[i] = 0; end
  endtask

  // Check the current cycle, advance the model by one clock, then step to the next cycle.
  task automatic cyc();
    int          hrel, vrel, idx, ta_n, hn, vn, stn;
    bit          hsr, vsr, win, act, pe, dt;
    logic [7:0]  ch, fb;
    logic [10:0] fa_n;

    check("busy", 32'(busy), 32'(m_st != 0));
    check("pixel_en", 32'(pixel_en), 32'(pe_p[0]));
    check("dot", 32'(dot), 32'(dt_p[0]));
    check("text_addr", 32'(text_addr), m_ta);
    check("hcnt", 32'(dut.u_sync_counters.hcnt), m_h);
    check("vcnt", 32'(dut.u_sync_counters.vcnt), m_v);
    if (fv_p[0]) check("font_addr", 32'(font_addr), 32'(fa_p[0]));

    if (m_v == 40 && m_h == 73) check("addr_r1c1", 32'(text_addr), 17);
    if (m_v == 40 && m_h == 75) check("font_r1c1", 32'(font_addr), 32'({text_ram[17], 3'd0}));

    if (pixel_en === 1'b1) pe_cnt++;
    if (cap_on && pixel_en === 1'b1 && cap_n < 8) begin
      if (cap_n == 0) begin first_h = m_h; first_v = m_v; end
      cap = {cap[6:0], dot};
      cap_n++;
    end

    hsr  = hsync && !m_hs;
    vsr  = vsync && !m_vs;
    hrel = m_h - X0;
    vrel = m_v - Y0;
    win  = hrel >= 0 && hrel < 8 * COLS && vrel >= 0 && vrel < 8 * ROWS;
    act  = m_st >= 2;
    idx  = win ? (vrel / 8) * COLS + hrel / 8 : 0;
    ta_n = win ? idx : m_ta;
    pe   = win && act;
    ch   = text_ram[idx];
    fb   = font_rom[{ch, 3'(vrel & 7)}];
    dt   = pe ? fb[7 - (hrel & 7)] : 1'b0;
    fa_n = {text_ram[ta_n], 3'(vrel & 7)};

    for (int i = 0; i < 4; i++) begin pe_p[i] = pe_p[i+1]; dt_p[i] = dt_p[i+1]; end
    pe_p[4] = pe; dt_p[4] = dt;
    for (int i = 0; i < 2; i++) begin fa_p[i] = fa_p[i+1]; fv_p[i] = fv_p[i+1]; end
    fa_p[2] = fa_n; fv_p[2] = 1'b1;

    stn = m_st;
    case (m_st)
      0: if (overlay_en) stn = 1;
      1: if (!overlay_en) stn = 0; else if (vsr) stn = 2;
      2: if (!overlay_en) stn = 3;
      default: if (overlay_en) stn = 2; else if (vsr) stn = 0;
    endcase
    hn = hsr ? 0 : (m_h < 2047 ? m_h + 1 : 2047);
    vn = vsr ? 0 : (hsr ? (m_v < 1023 ? m_v + 1 : 1023) : m_v);
    m_hs = hsync; m_vs = vsync;

    @(posedge clk);
    #1;
    m_h = hn; m_v = vn; m_st = stn; m_ta = ta_n;
  endtask

  task automatic idle(input int n);
    hsync = 0; vsync = 0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Reset asserted mid-cycle while overlay pixels are flowing.
  task automatic async_reset();
    check("pre_rst_pe", 32'(pixel_en), 1);
    rst = 1'b1;
    #1;
    check("rst_pe", 32'(pixel_en), 0);
    check("rst_dot", 32'(dot), 0);
    check("rst_busy", 32'(busy), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic frame(input int nlines, input int en_line, input bit en_val, input int rst_line);
    int len;
    for (int l = 0; l < nlines; l++) begin
      len = 200 + int'($urandom_range(0, 15));
      hsync = 1; vsync = (l == 0);
      cyc();
      hsync = 0; vsync = 0;
      for (int i = 1; i < len; i++) begin
        if (l == en_line && i == 100) overlay_en = en_val;
        if (l == rst_line && i == 100) async_reset();
        cyc();
      end
    end
  endtask

  initial begin
    rst = 1'b1; hsync = 0; vsync = 0; overlay_en = 0;
    pe_cnt = 0; cap_on = 0; cap_n = 0; cap = '0; first_h = 0; first_v = 0;
    for (int i = 0; i < COLS * ROWS; i++) text_ram[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) font_rom[i] = 8'($urandom);
    text_ram[0] = 8'h41;
    font_rom[{8'h41, 3'd0}] = 8'h18;

    repeat (3) @(posedge clk);
    #1;
    check("rst_state_busy", 32'(busy), 0);
    check("rst_state_pe", 32'(pixel_en), 0);
    check("rst_state_dot", 32'(dot), 0);
    check("rst_state_taddr", 32'(text_addr), 0);
    check("rst_state_faddr", 32'(font_addr), 0);
    check("rst_state_hcnt", 32'(dut.u_sync_counters.hcnt), 0);
    check("rst_state_vcnt", 32'(dut.u_sync_counters.vcnt), 0);
    rst = 1'b0;
    model_reset();
    idle(5);

    // Enable pulse with no frame start: armed, then back off.
    overlay_en = 1; cyc();
    overlay_en = 0;
    check("armed_busy", 32'(busy), 1);
    cyc();
    check("disarm_busy", 32'(busy), 0);
    idle(10);

    // Frame A: overlay switches on at the frame start.
    overlay_en = 1;
    idle(4);
    pe_cnt = 0; cap_on = 1;
    frame(66, -1, 1'b0, -1);
    cap_on = 0;
    check("frameA_pe_count", pe_cnt, 32 * 8 * COLS);
    check("first_pe_h", first_h, X0 + 5);
    check("first_pe_v", first_v, Y0);
    check("first_cell_dots", 32'(cap), 32'h18);

    // Frame B: request dropped mid-frame, frame still completes.
    pe_cnt = 0;
    frame(66, 45, 1'b0, -1);
    check("frameB_pe_count", pe_cnt, 32 * 8 * COLS);
    check("drain_busy", 32'(busy), 1);
    frame(2, -1, 1'b0, -1);
    check("drain_off", 32'(busy), 0);

    // Coincident sync edges, then a long line with no hsync.
    idle(3);
    hsync = 1; vsync = 1; cyc();
    hsync = 0; vsync = 0;
    check("coinc_hcnt", 32'(dut.u_sync_counters.hcnt), 0);
    check("coinc_vcnt", 32'(dut.u_sync_counters.vcnt), 0);
    idle(3000);
    check("hcnt_sat", 32'(dut.u_sync_counters.hcnt), 2047);

    // Frame D: reset mid-window; no output again until the next frame start.
    overlay_en = 1;
    idle(4);
    pe_cnt = 0;
    frame(66, -1, 1'b0, 33);
    check("post_rst_busy", 32'(busy), 1);

    // Frame E: overlay resumes at the frame start.
    pe_cnt = 0;
    frame(40, -1, 1'b0, -1);
    check("frameE_pe_count", pe_cnt, 8 * 8 * COLS);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/text_overlay_ctrl.md
TEXT_OVERLAY_CTRL -- requirements
Module: text_overlay_ctrl

Interface
REQ-001 Parameter COLS, default 16, text columns per overlay window.
REQ-002 Parameter ROWS, default 4, text rows per overlay window.
REQ-003 Parameter X0, default 64, first overlay pixel column.
REQ-004 Parameter Y0, default 32, first overlay line.
REQ-005 clk  in  1  single clock, one pixel per cycle; all logic SHALL be clocked on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 hsync  in  1  line sync pulse, active-high.
REQ-008 vsync  in  1  frame sync pulse, active-high.
REQ-009 overlay_en  in  1  overlay request level.
REQ-010 text_addr  out  clog2(COLS*ROWS)  character index into text RAM (6 bits at defaults).
REQ-011 text_data  in  8  character code from text RAM, registered read, valid 1 cycle after text_addr.
REQ-012 font_addr  out  11  {char code[7:0], glyph row[2:0]} into font ROM.
REQ-013 font_data  in  8  glyph row bits, registered read, valid 1 cycle after font_addr, MSB leftmost.
REQ-014 pixel_en  out  1  overlay window active for this pixel.
REQ-015 dot  out  1  glyph bit for this pixel; aligned with pixel_en.
REQ-016 busy  out  1  high when state is not OFF.

Function
REQ-017 Rising edges SHALL be detected by registering hsync/vsync: hs_rise = hsync & ~hsync_q, vs_rise = vsync & ~vsync_q.
REQ-018 hcnt (11 bits) SHALL load 0 on hs_rise, otherwise increment, saturating at 2047 (no wrap).
REQ-019 vcnt (10 bits) SHALL load 0 on vs_rise, otherwise increment on hs_rise, saturating at 1023; when both rises coincide, vs_rise wins.
REQ-020 In-window SHALL be X0 <= hcnt < X0+8*COLS and Y0 <= vcnt < Y0+8*ROWS; cells are 8x8 pixels.
REQ-021 For counter values (h,v) in cycle t: col = (h-X0)>>3, row = (v-Y0)>>3, text_addr = row*COLS+col, registered at end of t; text_addr SHALL hold its last value outside the window.
REQ-022 font_addr SHALL be registered at end of t+2 as {text_data, (v-Y0)[2:0]}.
REQ-023 dot SHALL be registered at end of t+4 as font_data[7-(h-X0)[2:0]]; pixel_en at end of t+4 as in-window AND overlay-active; total latency 5 cycles, side-band delayed in matching pipeline registers.
REQ-024 dot SHALL be 0 whenever pixel_en is 0.
REQ-025 FSM states OFF, ARMED, ON, DRAIN; overlay-active means state ON or DRAIN, sampled at cycle t.
REQ-026 OFF -> ARMED when overlay_en=1; ARMED -> ON on vs_rise; ARMED -> OFF when overlay_en=0 (before vs_rise).
REQ-027 ON -> DRAIN when overlay_en=0; DRAIN -> OFF on vs_rise; DRAIN -> ON when overlay_en=1 (before vs_rise).
REQ-028 In ARMED with overlay_en=1 and vs_rise in the same cycle, the state SHALL go to ON; in DRAIN with overlay_en=0 and vs_rise, to OFF.
REQ-029 Overlay SHALL therefore start and stop only at frame boundaries; no partial frames.

Reset
REQ-030 While rst=1: state OFF, hcnt=vcnt=0, sync registers 0, all pipeline registers 0, text_addr=0, font_addr=0, pixel_en=0, dot=0, busy=0.
REQ-031 Reset mid-frame SHALL abort immediately; after release, overlay resumes only via ARMED and the next vs_rise.

Structure
REQ-032 Shared package SHALL hold the FSM state encoding (2-bit: OFF=0, ARMED=1, ON=2, DRAIN=3), cell size 8, and counter widths 11/10.
REQ-033 One sub-module, sync_counters, SHALL contain edge detection and hcnt/vcnt; the FSM and 5-stage pipeline remain in text_overlay_ctrl.

Verification
REQ-034 Defaults, overlay_en=1 then vsync pulse, text RAM cell 0 = 0x41, font row 0 of 0x41 = 0x18 -> on line 32, pixel_en high for hcnt 64..191 (5 cycles late); dot pattern 00011000 in first cell.
REQ-035 Line 40, hcnt 72 -> text_addr = 17 (row 1, col 1), font_addr = {text_data, 3'd0}.
REQ-036 overlay_en dropped mid-frame -> busy stays 1, pixel_en continues to frame end, OFF after next vs_rise.
REQ-037 overlay_en pulsed 1 then 0 before any vsync -> ARMED then OFF, pixel_en never asserted.
REQ-038 hsync and vsync rise in the same cycle -> hcnt=0, vcnt=0 next cycle; no hsync for 3000 cycles -> hcnt holds 2047.
REQ-039 rst asserted while pixel_en=1 -> pixel_en, dot, busy 0 asynchronously; after release, no output until overlay_en=1 plus vs_rise.
